// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-cycle imem reads and buffers the
// returned words in a prefetch FIFO for decode. Define FETCH_MISALIGN_CHK_EN for the misalign fault.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fetch_fault
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fault_q, fault_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [31:0]   pcs_q  [DEPTH];
   logic [31:0]   pcs_d  [DEPTH];

   logic [31:0] tgt_pc;
   logic        tgt_bad;
   logic        pop;
   logic        push;
   logic        room;
   logic        issue;

`ifdef FETCH_MISALIGN_CHK_EN
   assign tgt_pc  = redirect_pc;
   assign tgt_bad = (redirect_pc[1:0] != 2'b00);
`else
   assign tgt_pc  = {redirect_pc[31:2], 2'b00};
   assign tgt_bad = 1'b0;
`endif

   always_comb begin
      instr_valid = rst_n && (count_q != '0);
      instr       = data_q[rd_ptr_q];
      instr_pc    = pcs_q[rd_ptr_q];
      fetch_fault = rst_n && fault_q;
      pop         = instr_valid && instr_ready;
      // A redirect kills the response landing this cycle.
      push        = inflight_q && !redirect_valid;
      // Issue only if the response is guaranteed a slot even when decode stalls next cycle.
      room        = (32'(count_q) + 32'(inflight_q) + 32'(!pop)) <= DEPTH;

      if (redirect_valid) begin
         issue = !halt && !tgt_bad;
      end else begin
         issue = !halt && !fault_q && room;
      end
      imem_req  = rst_n && issue;
      imem_addr = redirect_valid ? tgt_pc : fetch_pc_q;

      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = issue ? tgt_pc + 32'd4 : tgt_pc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      inflight_d    = issue;
      inflight_pc_d = imem_addr;
      fault_d       = redirect_valid ? tgt_bad : fault_q;

      data_d   = data_q;
      pcs_d    = pcs_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = imem_rdata;
            pcs_d[wr_ptr_q]  = inflight_pc_q;
            wr_ptr_d         = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         fault_q       <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         fault_q       <= fault_d;
      end
   end

   // Storage needs no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      pcs_q  <= pcs_d;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle expected request addresses and FIFO heads.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        fetch_fault;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;

   fetch_unit #(
      .RESET_PC (32'h8000_0000),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous memory: data one cycle after request, garbage otherwise.
   always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic exp_req(input string tag, input logic [31:0] addr);
      chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
      chk({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic exp_noreq(input string tag);
      chk({tag, "_noreq"}, {31'b0, imem_req}, 32'd0);
   endtask

   task automatic exp_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
      chk({tag, "_pc"}, instr_pc, pc);
      chk({tag, "_instr"}, instr, mem_word(pc));
   endtask

   task automatic exp_empty(input string tag);
      chk({tag, "_empty"}, {31'b0, instr_valid}, 32'd0);
   endtask

   task automatic exp_fault(input string tag, input logic f);
      chk({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, f});
   endtask

   initial begin
      rst_n          = 1'b0;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;

      // Reset and release with decode always ready
      mid(); exp_noreq("rst0"); exp_empty("rst0"); exp_fault("rst0", 1'b0);
      nxt(); mid(); exp_noreq("rst1"); exp_empty("rst1");
      nxt(); rst_n = 1'b1;
      mid(); exp_req("t1c0", 32'h8000_0000); exp_empty("t1c0"); exp_fault("t1c0", 1'b0);
      nxt(); mid(); exp_req("t1c1", 32'h8000_0004); exp_empty("t1c1");
      nxt(); mid(); exp_req("t1c2", 32'h8000_0008); exp_head("t1c2", 32'h8000_0000);
      nxt(); mid(); exp_req("t1c3", 32'h8000_000C); exp_head("t1c3", 32'h8000_0004);
      nxt(); mid(); exp_head("t1c4", 32'h8000_0008);

      // Reset mid-stream, then backpressure fills the FIFO
      nxt(); rst_n = 1'b0; instr_ready = 1'b0;
      mid(); exp_noreq("t2rst"); exp_empty("t2rst");
      nxt(); rst_n = 1'b1;
      mid(); exp_req("t2c0", 32'h8000_0000);
      nxt(); mid(); exp_req("t2c1", 32'h8000_0004);
      nxt(); mid(); exp_noreq("t2c2"); exp_head("t2c2", 32'h8000_0000);
      nxt(); mid(); exp_noreq("t2c3"); exp_head("t2c3", 32'h8000_0000);
      nxt(); mid(); exp_noreq("t2c4"); exp_head("t2c4", 32'h8000_0000);
      nxt(); instr_ready = 1'b1;
      mid(); exp_req("t2c5", 32'h8000_0008); exp_head("t2c5", 32'h8000_0000);
      nxt(); mid(); exp_req("t2c6", 32'h8000_000C); exp_head("t2c6", 32'h8000_0004);
      nxt(); mid(); exp_req("t2c7", 32'h8000_0010); exp_head("t2c7", 32'h8000_0008);

      // Redirect while the FIFO is full
      nxt(); instr_ready = 1'b0;
      mid(); exp_noreq("t3c8"); exp_head("t3c8", 32'h8000_000C);
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      mid(); exp_req("t3c9", 32'h8000_0100); exp_head("t3c9", 32'h8000_000C);
      nxt(); redirect_valid = 1'b0; instr_ready = 1'b1;
      mid(); exp_empty("t3c10"); exp_req("t3c10", 32'h8000_0104);
      nxt(); mid(); exp_head("t3c11", 32'h8000_0100); exp_req("t3c11", 32'h8000_0108);
      nxt(); mid(); exp_head("t3c12", 32'h8000_0104);

      // Redirect coinciding with a pop, then a second redirect the next cycle
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
      mid(); exp_head("t5c13", 32'h8000_0108); exp_req("t5c13", 32'h8000_0300);
      nxt(); redirect_pc = 32'h8000_0400;
      mid(); exp_empty("t5c14"); exp_req("t5c14", 32'h8000_0400);
      nxt(); redirect_valid = 1'b0;
      mid(); exp_empty("t5c15"); exp_req("t5c15", 32'h8000_0404);
      nxt(); mid(); exp_head("t5c16", 32'h8000_0400); exp_req("t5c16", 32'h8000_0408);
      nxt(); mid(); exp_head("t5c17", 32'h8000_0404); exp_req("t5c17", 32'h8000_040C);

      // Halt for five cycles: in-flight lands, FIFO drains, then resume sequentially
      nxt(); halt = 1'b1;
      mid(); exp_noreq("t4c18"); exp_head("t4c18", 32'h8000_0408);
      nxt(); mid(); exp_noreq("t4c19"); exp_head("t4c19", 32'h8000_040C);
      nxt(); mid(); exp_noreq("t4c20"); exp_empty("t4c20");
      nxt(); mid(); exp_noreq("t4c21"); exp_empty("t4c21");
      nxt(); mid(); exp_noreq("t4c22"); exp_empty("t4c22");
      nxt(); halt = 1'b0;
      mid(); exp_req("t4c23", 32'h8000_0410); exp_empty("t4c23");
      nxt(); mid(); exp_req("t4c24", 32'h8000_0414); exp_empty("t4c24");
      nxt(); mid(); exp_head("t4c25", 32'h8000_0410); exp_req("t4c25", 32'h8000_0418);

      // Redirect during halt only retargets the fetch PC
      nxt(); halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
      mid(); exp_noreq("hrc26"); exp_head("hrc26", 32'h8000_0414);
      nxt(); redirect_valid = 1'b0;
      mid(); exp_noreq("hrc27"); exp_empty("hrc27");
      nxt(); halt = 1'b0;
      mid(); exp_req("hrc28", 32'h8000_0500); exp_empty("hrc28");
      nxt(); mid(); exp_req("hrc29", 32'h8000_0504); exp_empty("hrc29");
      nxt(); mid(); exp_head("hrc30", 32'h8000_0500); exp_req("hrc30", 32'h8000_0508);

      // Misaligned redirect target
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
`ifdef FETCH_MISALIGN_CHK_EN
      mid(); exp_noreq("t6c31"); exp_fault("t6c31", 1'b0);
      nxt(); redirect_valid = 1'b0;
      mid(); exp_fault("t6c32", 1'b1); exp_noreq("t6c32"); exp_empty("t6c32");
      nxt(); mid(); exp_fault("t6c33", 1'b1); exp_noreq("t6c33"); exp_empty("t6c33");
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      mid(); exp_req("t6c34", 32'h8000_0200);
      nxt(); redirect_valid = 1'b0;
      mid(); exp_fault("t6c35", 1'b0); exp_empty("t6c35"); exp_req("t6c35", 32'h8000_0204);
      nxt(); mid(); exp_head("t6c36", 32'h8000_0200);
`else
      mid(); exp_req("t6c31", 32'h8000_0100); exp_fault("t6c31", 1'b0);
      nxt(); redirect_valid = 1'b0;
      mid(); exp_empty("t6c32"); exp_req("t6c32", 32'h8000_0104); exp_fault("t6c32", 1'b0);
      nxt(); mid(); exp_head("t6c33", 32'h8000_0100);
`endif

      // PC wraps from 0xFFFF_FFFC to 0
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      mid(); exp_req("wr0", 32'hFFFF_FFF8);
      nxt(); redirect_valid = 1'b0;
      mid(); exp_req("wr1", 32'hFFFF_FFFC); exp_empty("wr1");
      nxt(); mid(); exp_req("wr2", 32'h0000_0000); exp_head("wr2", 32'hFFFF_FFF8);
      nxt(); mid(); exp_req("wr3", 32'h0000_0004); exp_head("wr3", 32'hFFFF_FFFC);
      nxt(); mid(); exp_head("wr4", 32'h0000_0000);

      // Reset in steady state: stale response afterwards must be ignored
      nxt(); rst_n = 1'b0;
      mid(); exp_noreq("mr"); exp_empty("mr"); exp_fault("mr", 1'b0);
      nxt(); rst_n = 1'b1;
      mid(); exp_req("mr0", 32'h8000_0000); exp_empty("mr0");
      nxt(); mid(); exp_empty("mr1"); exp_req("mr1", 32'h8000_0004);
      nxt(); mid(); exp_head("mr2", 32'h8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
